// File: rtl/ram_uart_pkg.sv
// rtl/ram_uart_pkg.sv - shared state encoding and RAM1 strobe levels
package ram_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD,
        RD_SETUP,
        RD_WAIT,
        RD_OUT
    } state_t;

    localparam logic STROBE_ON  = 1'b0;
    localparam logic STROBE_OFF = 1'b1;

endpackage

// File: rtl/ram1_byte_store_if.sv
// rtl/ram1_byte_store_if.sv - byte ingress, replay egress and dump control
interface ram1_byte_store_if;

    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       dump_start;
    logic       clear;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic       dump_done;

    modport master (
        output in_valid, in_data, dump_start, clear, out_ready,
        input  in_ready, out_valid, out_data, dump_done
    );

    modport slave (
        input  in_valid, in_data, dump_start, clear, out_ready,
        output in_ready, out_valid, out_data, dump_done
    );

endinterface

// File: rtl/ram1_byte_store_strobe_timer.sv
// rtl/ram1_byte_store_strobe_timer.sv - loadable down-counter timing the SRAM strobe width
module ram1_strobe_timer #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic expired
);

    localparam int CNT_W = $clog2(WAIT_CYCLES + 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CNT_W'(WAIT_CYCLES);
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // Loaded one cycle before the strobe phase, so a value of 1 marks its last cycle.
    assign expired = (cnt == CNT_W'(1));

endmodule

// File: rtl/ram1_byte_store.sv
// rtl/ram1_byte_store.sv - stores received bytes sequentially in RAM1 and replays them on request
module ram1_byte_store
    import ram_uart_pkg::*;
#(
    parameter int ADDR_W      = 18,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    ram1_byte_store_if.slave    bus,
    output logic [ADDR_W:0]     count,
    output logic                full,
    output logic [ADDR_W-1:0]   ram1_addr,
    inout  wire  [DATA_W-1:0]   ram1_data,
    output logic                ram1_en,
    output logic                ram1_oe,
    output logic                ram1_we
);

    localparam logic [ADDR_W:0]   CAPACITY = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W-1:0] LAST_PTR = {ADDR_W{1'b1}};

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W:0]   rd_ptr;
    logic [7:0]        wr_byte;
    logic [7:0]        out_byte;
    logic              dump_done_q;
    logic              drive_bus;
    logic              timer_load;
    logic              timer_expired;
    logic              accept;
    logic              last_rd;

    ram1_strobe_timer #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (timer_load),
        .expired (timer_expired)
    );

    assign full          = (count == CAPACITY);
    assign bus.in_ready  = (state == IDLE) & ~full & ~bus.dump_start & ~bus.clear;
    assign accept        = bus.in_valid & bus.in_ready;
    assign last_rd       = ((rd_ptr + (ADDR_W+1)'(1)) == count);
    assign bus.out_valid = (state == RD_OUT);
    assign bus.out_data  = out_byte;
    assign bus.dump_done = dump_done_q;
    assign ram1_data     = drive_bus ? DATA_W'(wr_byte) : {DATA_W{1'bz}};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        timer_load = 1'b0;
        drive_bus  = 1'b0;
        ram1_addr  = '0;
        ram1_en    = STROBE_OFF;
        ram1_oe    = STROBE_OFF;
        ram1_we    = STROBE_OFF;
        case (state)
            IDLE: begin
                if (!bus.clear && bus.dump_start && count != '0) begin
                    state_nxt = RD_SETUP;
                end else if (accept) begin
                    state_nxt = WR_SETUP;
                end
            end
            WR_SETUP: begin
                ram1_en    = STROBE_ON;
                ram1_addr  = wr_ptr;
                drive_bus  = 1'b1;
                timer_load = 1'b1;
                state_nxt  = WR_PULSE;
            end
            WR_PULSE: begin
                ram1_en   = STROBE_ON;
                ram1_we   = STROBE_ON;
                ram1_addr = wr_ptr;
                drive_bus = 1'b1;
                if (timer_expired) begin
                    state_nxt = WR_HOLD;
                end
            end
            WR_HOLD: begin
                ram1_en   = STROBE_ON;
                ram1_addr = wr_ptr;
                drive_bus = 1'b1;
                state_nxt = IDLE;
            end
            RD_SETUP: begin
                ram1_en    = STROBE_ON;
                ram1_oe    = STROBE_ON;
                ram1_addr  = rd_ptr[ADDR_W-1:0];
                timer_load = 1'b1;
                state_nxt  = RD_WAIT;
            end
            RD_WAIT: begin
                ram1_en   = STROBE_ON;
                ram1_oe   = STROBE_ON;
                ram1_addr = rd_ptr[ADDR_W-1:0];
                if (timer_expired) begin
                    state_nxt = RD_OUT;
                end
            end
            RD_OUT: begin
                ram1_en   = STROBE_ON;
                ram1_addr = rd_ptr[ADDR_W-1:0];
                if (bus.out_ready) begin
                    state_nxt = last_rd ? IDLE : RD_SETUP;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            wr_byte     <= '0;
            out_byte    <= '0;
            dump_done_q <= 1'b0;
        end else begin
            dump_done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.clear) begin
                        wr_ptr <= '0;
                        count  <= '0;
                    end else if (bus.dump_start) begin
                        rd_ptr <= '0;
                        if (count == '0) begin
                            dump_done_q <= 1'b1;
                        end
                    end else if (accept) begin
                        wr_byte <= bus.in_data;
                    end
                end
                WR_HOLD: begin
                    // The pointer parks on the last word so a full store never wraps.
                    if (wr_ptr != LAST_PTR) begin
                        wr_ptr <= wr_ptr + ADDR_W'(1);
                    end
                    count <= count + (ADDR_W+1)'(1);
                end
                RD_WAIT: begin
                    if (timer_expired) begin
                        out_byte <= ram1_data[7:0];
                    end
                end
                RD_OUT: begin
                    if (bus.out_ready) begin
                        rd_ptr <= rd_ptr + (ADDR_W+1)'(1);
                        if (last_rd) begin
                            dump_done_q <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram1_byte_store.sv
// tb/tb_ram1_byte_store.sv - scoreboard bench for ram1_byte_store with an SRAM model
module tb_ram1_byte_store;

    localparam int AW = 4;
    localparam int DW = 16;
    localparam int WC = 2;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } xfer_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [AW:0]     count;
    logic            full;
    logic [AW-1:0]   ram1_addr;
    wire  [DW-1:0]   ram1_data;
    logic            ram1_en;
    logic            ram1_oe;
    logic            ram1_we;

    ram1_byte_store_if bus();

    ram1_byte_store #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .WAIT_CYCLES (WC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .count     (count),
        .full      (full),
        .ram1_addr (ram1_addr),
        .ram1_data (ram1_data),
        .ram1_en   (ram1_en),
        .ram1_oe   (ram1_oe),
        .ram1_we   (ram1_we)
    );

    always #5 clk = ~clk;

    logic [7:0] sram [16];
    always @(posedge clk) begin
        if (!ram1_en && !ram1_we) sram[ram1_addr] <= ram1_data[7:0];
    end
    assign ram1_data = (!ram1_en && !ram1_oe) ? {8'h00, sram[ram1_addr]} : 16'hzzzz;

    xfer_t      wr_q[$];
    xfer_t      rd_q[$];
    logic [7:0] exp_mem [16];
    int         exp_cnt = 0;
    int         n_cmp = 0;
    int         n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the write/read scoreboards whenever the DUT presents a transfer.
    logic prev_we = 1'b1;
    always @(negedge clk) begin : monitor
        xfer_t e;
        if (!rst) begin
            check("we_oe_excl", 32'(ram1_we | ram1_oe), 1);
            if (!ram1_en && !ram1_we && prev_we) begin
                if (wr_q.size() == 0) begin
                    check("wr_unexpected", 1, 0);
                end else begin
                    e = wr_q.pop_front();
                    check("wr_addr", 32'(ram1_addr), 32'(e.addr));
                    check("wr_data", 32'(ram1_data), 32'(e.data));
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                if (rd_q.size() == 0) begin
                    check("rd_unexpected", 1, 0);
                end else begin
                    e = rd_q.pop_front();
                    check("rd_addr", 32'(ram1_addr), 32'(e.addr));
                    check("rd_data", 32'(bus.out_data), 32'(e.data));
                end
            end
        end
        prev_we = ram1_we;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [7:0] b);
        bit ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        for (int i = 0; i < 40 && !ok; i++) begin
            #1;
            if (bus.in_ready) begin
                ok = 1'b1;
                wr_q.push_back(xfer_t'({AW'(exp_cnt), b}));
                exp_mem[exp_cnt] = b;
                exp_cnt++;
            end
            step();
        end
        bus.in_valid = 1'b0;
        check("send_accepted", 32'(ok), 1);
        repeat (WC + 2) step();
    endtask

    task automatic run_dump(input bit stall, input bit pulse_clear);
        int  acc  = 0;
        int  last = -1;
        bit  done = 1'b0;
        for (int i = 0; i < exp_cnt; i++) rd_q.push_back(xfer_t'({AW'(i), exp_mem[i]}));
        bus.dump_start = 1'b1;
        step();
        bus.dump_start = 1'b0;
        bus.out_ready  = !stall;
        bus.clear      = pulse_clear;
        for (int k = 1; k <= WC + 1; k++) begin
            #1;
            check("valid_early", 32'(bus.out_valid), 0);
            check("in_ready_dump", 32'(bus.in_ready), 0);
            step();
            bus.clear = 1'b0;
        end
        #1;
        check("first_valid", 32'(bus.out_valid), 1);
        if (stall) begin
            for (int k = 0; k < 10; k++) begin
                check("stall_valid", 32'(bus.out_valid), 1);
                check("stall_data", 32'(bus.out_data), 32'(exp_mem[0]));
                check("stall_oe", 32'(ram1_oe), 1);
                step();
                #1;
            end
            bus.out_ready = 1'b1;
        end
        for (int c = 0; c < 200; c++) begin
            if (bus.dump_done) begin
                done = 1'b1;
                check("dump_done_lat", c, last + 1);
                break;
            end
            if (bus.out_valid && bus.out_ready) begin
                acc++;
                last = c;
            end
            step();
            #1;
        end
        check("dump_done_seen", 32'(done), 1);
        check("dump_accepts", acc, exp_cnt);
        bus.out_ready = 1'b0;
        step();
        #1;
        check("dump_done_pulse", 32'(bus.dump_done), 0);
        check("count_after_dump", 32'(count), exp_cnt);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.in_valid   = 1'b0;
        bus.in_data    = 8'h00;
        bus.dump_start = 1'b0;
        bus.clear      = 1'b0;
        bus.out_ready  = 1'b0;
        rst            = 1'b1;
        repeat (2) step();
        #1;
        check("rst_en", 32'(ram1_en), 1);
        check("rst_oe", 32'(ram1_oe), 1);
        check("rst_we", 32'(ram1_we), 1);
        check("rst_addr", 32'(ram1_addr), 0);
        check("rst_count", 32'(count), 0);
        check("rst_full", 32'(full), 0);
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_out_data", 32'(bus.out_data), 0);
        check("rst_dump_done", 32'(bus.dump_done), 0);
        rst = 1'b0;
        step();

        // Single write of 0x41, cycle by cycle.
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h41;
        #1;
        check("t1_in_ready", 32'(bus.in_ready), 1);
        wr_q.push_back(xfer_t'({4'd0, 8'h41}));
        exp_mem[0] = 8'h41;
        exp_cnt    = 1;
        step();
        bus.in_valid = 1'b0;
        #1;
        check("t1_c1_en", 32'(ram1_en), 0);
        check("t1_c1_we", 32'(ram1_we), 1);
        step(); #1;
        check("t1_c2_we", 32'(ram1_we), 0);
        check("t1_c2_addr", 32'(ram1_addr), 0);
        check("t1_c2_data", 32'(ram1_data), 32'h0041);
        step(); #1;
        check("t1_c3_we", 32'(ram1_we), 0);
        step(); #1;
        check("t1_c4_we", 32'(ram1_we), 1);
        check("t1_c4_count", 32'(count), 0);
        step(); #1;
        check("t1_c5_count", 32'(count), 1);
        check("t1_c5_en", 32'(ram1_en), 1);
        check("t1_c5_in_ready", 32'(bus.in_ready), 1);
        step();

        // Three bytes, then a free-flowing dump and a stalled dump.
        bus.clear = 1'b1;
        #1;
        check("clr_in_ready", 32'(bus.in_ready), 0);
        step();
        bus.clear = 1'b0;
        exp_cnt   = 0;
        #1;
        check("clr_count", 32'(count), 0);
        send(8'h10);
        send(8'h20);
        send(8'h30);
        #1;
        check("t2_count", 32'(count), 3);
        step();
        run_dump(1'b0, 1'b0);
        step();
        run_dump(1'b1, 1'b0);
        step();

        // Fill to capacity; the 17th byte must be refused.
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
        exp_cnt   = 0;
        for (int i = 0; i < 15; i++) send(8'h80 + 8'(i));
        #1;
        check("fill15_count", 32'(count), 15);
        check("fill15_full", 32'(full), 0);
        step();
        send(8'h8F);
        #1;
        check("fill16_count", 32'(count), 16);
        check("fill16_full", 32'(full), 1);
        step();
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hEE;
        for (int k = 0; k < 10; k++) begin
            #1;
            check("full_in_ready", 32'(bus.in_ready), 0);
            step();
        end
        bus.in_valid = 1'b0;
        #1;
        check("full_count_hold", 32'(count), 16);
        step();
        run_dump(1'b0, 1'b0);
        step();

        // dump_start and in_valid together: the byte waits for the dump to finish.
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
        exp_cnt   = 0;
        send(8'hA1);
        send(8'hA2);
        rd_q.push_back(xfer_t'({4'd0, 8'hA1}));
        rd_q.push_back(xfer_t'({4'd1, 8'hA2}));
        bus.dump_start = 1'b1;
        bus.in_valid   = 1'b1;
        bus.in_data    = 8'hB3;
        bus.out_ready  = 1'b1;
        #1;
        check("race_in_ready", 32'(bus.in_ready), 0);
        step();
        bus.dump_start = 1'b0;
        begin
            bit seen = 1'b0;
            for (int c = 0; c < 100; c++) begin
                #1;
                if (bus.dump_done) begin
                    seen = 1'b1;
                    break;
                end
                check("race_pending", 32'(bus.in_ready), 0);
                step();
            end
            check("race_dump_done", 32'(seen), 1);
        end
        check("race_accept", 32'(bus.in_ready), 1);
        wr_q.push_back(xfer_t'({4'd2, 8'hB3}));
        exp_mem[2] = 8'hB3;
        exp_cnt    = 3;
        bus.out_ready = 1'b0;
        step();
        bus.in_valid = 1'b0;
        repeat (WC + 2) step();
        #1;
        check("race_count", 32'(count), 3);
        step();

        // Reset in the middle of WR_PULSE aborts the write.
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h55;
        #1;
        check("abort_in_ready", 32'(bus.in_ready), 1);
        wr_q.push_back(xfer_t'({4'd3, 8'h55}));
        step();
        bus.in_valid = 1'b0;
        step();
        #4;
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_cnt = 0;
        #1;
        check("abort_we", 32'(ram1_we), 1);
        check("abort_en", 32'(ram1_en), 1);
        check("abort_oe", 32'(ram1_oe), 1);
        check("abort_count", 32'(count), 0);
        step();

        // Empty dump answers immediately.
        bus.dump_start = 1'b1;
        step();
        bus.dump_start = 1'b0;
        #1;
        check("empty_dump_done", 32'(bus.dump_done), 1);
        check("empty_out_valid", 32'(bus.out_valid), 0);
        step();
        #1;
        check("empty_dump_pulse", 32'(bus.dump_done), 0);
        step();

        // clear during a dump is ignored; a repeat dump replays the same bytes.
        send(8'h66);
        send(8'h77);
        run_dump(1'b0, 1'b1);
        step();
        run_dump(1'b0, 1'b0);
        step();

        check("wr_q_drained", wr_q.size(), 0);
        check("rd_q_drained", rd_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
